// File: rtl/rf_scoreboard_pkg.sv
// Shared types and default parameters for the register-file scoreboard.
package rf_scoreboard_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_NRD      = 2;
  localparam int unsigned DEF_ZERO_REG = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/rf_pending.sv
// Per-register pending-producer bits with set/clear/sweep priority.
module rf_pending
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [ADDR_W-1:0]       set_addr,
  input  logic                    clr_en,
  input  logic [ADDR_W-1:0]       clr_addr,
  input  logic                    sweep_en,
  input  logic [ADDR_W-1:0]       sweep_addr,
  output logic [(1<<ADDR_W)-1:0]  pending
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Set after clear so a same-cycle issue overrides the writeback.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_addr] = 1'b0;
    end
    if (set_en) begin
      pending_d[set_addr] = 1'b1;
    end
    if (sweep_en) begin
      pending_d[sweep_addr] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with write-through bypass, pending-producer tracking and
// a one-register-per-cycle sweep clear.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NRD      = DEF_NRD,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  alloc_en,
  input  logic [ADDR_W-1:0]     alloc_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  localparam int unsigned       NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NREGS - 1);
  localparam bit                ZR    = (ZERO_REG != 0);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                clr_done_q, clr_done_d;
  logic [DATA_W-1:0]   data_q [NREGS];
  logic [DATA_W-1:0]   data_d [NREGS];
  logic [NREGS-1:0]    pending;
  logic                idle;
  logic                wr_ok;
  logic                alloc_ok;

  assign idle     = (state_q == ST_IDLE);
  assign wr_ok    = idle && wr_en    && !(ZR && (wr_addr == '0));
  assign alloc_ok = idle && alloc_en && !(ZR && (alloc_addr == '0));

  rf_pending #(
    .ADDR_W (ADDR_W)
  ) u_pending (
    .clk        (clk),
    .rst        (rst),
    .set_en     (alloc_ok),
    .set_addr   (alloc_addr),
    .clr_en     (wr_ok),
    .clr_addr   (wr_addr),
    .sweep_en   (!idle),
    .sweep_addr (cnt_q),
    .pending    (pending)
  );

  // Sweep FSM: walks cnt over every register, then pulses clr_done.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (wr_ok) begin
      data_d[wr_addr] = wr_data;
    end
    if (!idle) begin
      data_d[cnt_q] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      clr_done_q <= 1'b0;
      data_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_done_q <= clr_done_d;
      data_q     <= data_d;
    end
  end

  assign clr_busy = !idle;
  assign clr_done = clr_done_q;

  // Combinational read ports; a same-cycle writeback bypasses the array.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              byp;

    assign addr    = rd_addr[k*ADDR_W +: ADDR_W];
    assign is_zero = ZR && (addr == '0);
    assign byp     = idle && wr_en && (wr_addr == addr);

    assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0 :
                                         byp     ? wr_data : data_q[addr];
    assign rd_busy[k] = idle && !is_zero && !byp && pending[addr];
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed plus randomized bench for rf_scoreboard against a behavioural model.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        alloc_en;
  logic [4:0]  alloc_addr;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_data [32];
  bit          m_pend [32];
  bit          m_sweep;
  bit          m_done;
  int          m_idx;

  rf_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs derived from the model and the inputs currently driven.
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int          a;
      logic [31:0] ed;
      logic        eb;
      a = int'(rd_addr[k*5 +: 5]);
      if (a == 0) begin
        ed = 32'h0;
        eb = 1'b0;
      end else if (!m_sweep && wr_en && int'(wr_addr) == a) begin
        ed = wr_data;
        eb = 1'b0;
      end else begin
        ed = m_data[a];
        eb = m_sweep ? 1'b0 : m_pend[a];
      end
      check($sformatf("rd_data[%0d] r%0d", k, a), rd_data[k*32 +: 32], ed);
      check($sformatf("rd_busy[%0d] r%0d", k, a), 32'(rd_busy[k]), 32'(eb));
    end
    check("clr_busy", 32'(clr_busy), 32'(m_sweep));
    check("clr_done", 32'(clr_done), 32'(m_done));
  endtask

  // Advance one clock edge, applying the same edge to the model.
  task automatic tick();
    @(posedge clk);
    m_done = 1'b0;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_data[i] = 32'h0;
        m_pend[i] = 1'b0;
      end
      m_sweep = 1'b0;
      m_idx   = 0;
    end else if (m_sweep) begin
      m_data[m_idx] = 32'h0;
      m_pend[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == 32) begin
        m_sweep = 1'b0;
        m_done  = 1'b1;
      end
    end else begin
      if (wr_en && wr_addr != 5'd0) begin
        m_data[wr_addr] = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (alloc_en && alloc_addr != 5'd0) m_pend[alloc_addr] = 1'b1;
      if (clr_req) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end
    end
    #1;
  endtask

  task automatic set_idle();
    rst      = 1'b0;
    wr_en    = 1'b0;
    alloc_en = 1'b0;
    clr_req  = 1'b0;
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 32; a++) begin
      set_idle();
      rd_addr = {5'(31 - a), 5'(a)};
      #2;
      check_all();
      check("zero_after_clear", rd_data[31:0], 32'h0);
      tick();
    end
  endtask

  task automatic fill_regs();
    for (int a = 1; a < 32; a++) begin
      set_idle();
      wr_en      = 1'b1;
      wr_addr    = 5'(a);
      wr_data    = $urandom | 32'h1;
      alloc_en   = (a % 3 == 0);
      alloc_addr = 5'(32 - a);
      rd_addr    = {5'(a), 5'($urandom)};
      #2;
      check_all();
      tick();
    end
  endtask

  initial begin
    int n_busy;
    int n_done;

    for (int i = 0; i < 32; i++) begin
      m_data[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_sweep = 1'b0;
    m_done  = 1'b0;
    m_idx   = 0;

    set_idle();
    rst        = 1'b1;
    rd_addr    = 10'h0;
    wr_addr    = 5'd0;
    wr_data    = 32'h0;
    alloc_addr = 5'd0;
    tick();
    tick();
    set_idle();
    for (int a = 0; a < 32; a += 7) begin
      rd_addr = {5'(a), 5'(a + 3)};
      #2;
      check_all();
      check("reset_busy", 32'(rd_busy), 32'h0);
      tick();
    end

    // Write then read back on both ports.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    #2; check_all(); tick();
    set_idle(); rd_addr = {5'd5, 5'd5};
    #2; check_all();
    check("r5_port0", rd_data[31:0], 32'hDEADBEEF);
    check("r5_port1", rd_data[63:32], 32'hDEADBEEF);
    check("r5_busy", 32'(rd_busy), 32'h0);
    tick();

    // Same-cycle bypass on port 1.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234; rd_addr = {5'd7, 5'd5};
    #2; check_all();
    check("bypass_r7", rd_data[63:32], 32'h1234);
    tick();

    // Allocate, observe busy, then writeback clears it.
    set_idle(); alloc_en = 1'b1; alloc_addr = 5'd3;
    #2; check_all(); tick();
    set_idle(); rd_addr = {5'd3, 5'd3};
    #2; check_all();
    check("r3_busy", 32'(rd_busy), 32'h3);
    tick();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    #2; check_all();
    check("r3_busy_bypass", 32'(rd_busy), 32'h0);
    tick();
    set_idle();
    #2; check_all();
    check("r3_data", rd_data[31:0], 32'h55);
    tick();

    // Alloc and write to the same register: new producer wins.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_0009;
    alloc_en = 1'b1; alloc_addr = 5'd9;
    #2; check_all(); tick();
    set_idle(); rd_addr = {5'd9, 5'd9};
    #2; check_all();
    check("r9_data", rd_data[31:0], 32'hA5A5_0009);
    check("r9_busy", 32'(rd_busy[0]), 32'h1);
    tick();

    // Register 0 ignores writes and allocations.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    alloc_en = 1'b1; alloc_addr = 5'd0; rd_addr = 10'h0;
    #2; check_all();
    check("r0_data_bypass", rd_data[31:0], 32'h0);
    tick();
    set_idle();
    #2; check_all();
    check("r0_data", rd_data[31:0], 32'h0);
    check("r0_busy", 32'(rd_busy), 32'h0);
    tick();

    // Full sweep with writes attempted throughout.
    fill_regs();
    set_idle(); clr_req = 1'b1;
    #2; check_all(); tick();
    n_busy = 0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      set_idle();
      clr_req  = (c == 5);
      wr_en    = (c < 32);
      wr_addr  = 5'($urandom_range(1, 31));
      wr_data  = $urandom;
      alloc_en = (c < 32);
      alloc_addr = wr_addr;
      rd_addr  = {wr_addr, 5'($urandom)};
      #2; check_all();
      if (clr_busy === 1'b1) n_busy++;
      if (clr_done === 1'b1) n_done++;
      tick();
    end
    check("sweep_len", 32'(n_busy), 32'd32);
    check("done_pulses", 32'(n_done), 32'd1);
    read_all_zero();

    // Reset in the middle of a sweep.
    fill_regs();
    set_idle(); clr_req = 1'b1;
    #2; check_all(); tick();
    set_idle();
    for (int c = 0; c < 10; c++) begin
      rd_addr = 10'($urandom);
      #2; check_all(); tick();
    end
    rst = 1'b1;
    #2; check_all(); tick();
    set_idle();
    #2; check_all();
    check("rst_mid_sweep_busy", 32'(clr_busy), 32'h0);
    check("rst_mid_sweep_done", 32'(clr_done), 32'h0);
    read_all_zero();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 149) == 0);
      clr_req    = ($urandom_range(0, 59) == 0);
      wr_en      = 1'($urandom_range(0, 1));
      wr_addr    = 5'($urandom);
      wr_data    = $urandom;
      alloc_en   = ($urandom_range(0, 2) == 0);
      alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rd_addr[4:0] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      rd_addr[9:5] = ($urandom_range(0, 2) == 0) ? alloc_addr : 5'($urandom);
      #2; check_all();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
